// File: rtl/uart_tx_burst_seq_if.sv
// Handshake bundle between the burst sequencer and tx_module.
// master = sequencer (drives request and data), slave = tx_module (returns done).
`timescale 1ns/1ps
interface uart_tx_burst_seq_if;
  logic       Tx_En_Sig;
  logic [7:0] Tx_Data;
  logic       Tx_Done_Sig;

  modport master (output Tx_En_Sig, output Tx_Data, input Tx_Done_Sig);
  modport slave  (input Tx_En_Sig, input Tx_Data, output Tx_Done_Sig);
endinterface

// File: rtl/uart_tx_burst_seq.sv
// Periodic UART burst sequencer: BURST_LEN bytes every PERIOD_CYCLES clocks.
// Define UART_TX_BURST_CHKSUM_EN to append an XOR checksum byte to each burst.
`timescale 1ns/1ps
module uart_tx_burst_seq #(
  parameter int         PERIOD_CYCLES = 50_000_000,
  parameter int         BURST_LEN     = 4,
  parameter logic [7:0] START_VAL     = 8'h00
) (
  input  logic                       CLK,
  input  logic                       RST_n,
  input  logic                       Enable,
  input  logic                       Mode,
  uart_tx_burst_seq_if.master        tx,
  output logic                       Busy,
  output logic                       Burst_Done_Sig,
  output logic                       Overrun
);

  localparam int               CNT_W     = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [7:0]       LAST_BYTE = 8'(BURST_LEN);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] period_cnt_reg;
  logic             pending_reg;
  logic             mode_reg;
  logic [7:0]       byte_cnt_reg;
  logic [7:0]       cnt_val_reg;
  logic [7:0]       walk_reg;
`ifdef UART_TX_BURST_CHKSUM_EN
  logic [7:0]       xor_reg;
  logic             chk_sent_reg;
`endif

  logic       tick;
  logic       consume;
  logic [7:0] src_val;

  assign tick    = Enable && (period_cnt_reg == CNT_MAX);
  assign consume = (state_reg == IDLE) && pending_reg && Enable;
  assign src_val = mode_reg ? walk_reg : cnt_val_reg;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      period_cnt_reg <= '0;
    end else if (!Enable || tick) begin
      period_cnt_reg <= '0;
    end else begin
      period_cnt_reg <= period_cnt_reg + 1'b1;
    end
  end

  // A tick in the same cycle IDLE consumes the flag re-arms it; only a
  // tick landing on an unconsumed flag is a lost burst.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      pending_reg <= 1'b0;
      Overrun     <= 1'b0;
    end else if (tick) begin
      pending_reg <= 1'b1;
      if (pending_reg && !consume)
        Overrun <= 1'b1;
    end else if (consume || (state_reg == IDLE && !Enable)) begin
      pending_reg <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_reg      <= IDLE;
      tx.Tx_En_Sig   <= 1'b0;
      tx.Tx_Data     <= START_VAL;
      Busy           <= 1'b0;
      Burst_Done_Sig <= 1'b0;
      mode_reg       <= 1'b0;
      byte_cnt_reg   <= 8'd0;
      cnt_val_reg    <= START_VAL;
      walk_reg       <= 8'h01;
`ifdef UART_TX_BURST_CHKSUM_EN
      xor_reg        <= 8'h00;
      chk_sent_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (pending_reg && Enable) begin
            mode_reg     <= Mode;
            byte_cnt_reg <= 8'd0;
            Busy         <= 1'b1;
            tx.Tx_Data   <= Mode ? walk_reg : cnt_val_reg;
            tx.Tx_En_Sig <= 1'b1;
`ifdef UART_TX_BURST_CHKSUM_EN
            xor_reg      <= 8'h00;
            chk_sent_reg <= 1'b0;
`endif
            state_reg    <= SEND;
          end
        end
        SEND: begin
          if (tx.Tx_Done_Sig) begin
            tx.Tx_En_Sig <= 1'b0;
            state_reg    <= GAP;
`ifdef UART_TX_BURST_CHKSUM_EN
            if (!chk_sent_reg) begin
              xor_reg <= xor_reg ^ tx.Tx_Data;
`else
            begin
`endif
              byte_cnt_reg <= byte_cnt_reg + 8'd1;
              if (mode_reg)
                walk_reg <= {walk_reg[6:0], walk_reg[7]};
              else
                cnt_val_reg <= cnt_val_reg + 8'd1;
            end
          end
        end
        GAP: begin
          if (byte_cnt_reg != LAST_BYTE) begin
            tx.Tx_Data   <= src_val;
            tx.Tx_En_Sig <= 1'b1;
            state_reg    <= SEND;
`ifdef UART_TX_BURST_CHKSUM_EN
          end else if (!chk_sent_reg) begin
            tx.Tx_Data   <= xor_reg;
            tx.Tx_En_Sig <= 1'b1;
            chk_sent_reg <= 1'b1;
            state_reg    <= SEND;
`endif
          end else begin
            Burst_Done_Sig <= 1'b1;
            state_reg      <= DONE;
          end
        end
        DONE: begin
          Burst_Done_Sig <= 1'b0;
          Busy           <= 1'b0;
          state_reg      <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_burst_seq.sv
// Scoreboard bench for uart_tx_burst_seq: stimulus pushes expected bytes,
// monitors pop and compare on every Tx_En_Sig rise. Honours UART_TX_BURST_CHKSUM_EN.
`timescale 1ns/1ps
module tb_uart_tx_burst_seq;
  localparam int PERIOD = 100;
  localparam int BLEN   = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0, mode = 1'b0, enable_b = 1'b0;
  logic busy, bdone, ovr, busy_b, bdone_b, ovr_b;

  uart_tx_burst_seq_if txa ();
  uart_tx_burst_seq_if txb ();

  uart_tx_burst_seq #(.PERIOD_CYCLES(PERIOD), .BURST_LEN(BLEN), .START_VAL(8'h00)) dut (
    .CLK(clk), .RST_n(rst_n), .Enable(enable), .Mode(mode), .tx(txa.master),
    .Busy(busy), .Burst_Done_Sig(bdone), .Overrun(ovr));

  uart_tx_burst_seq #(.PERIOD_CYCLES(PERIOD), .BURST_LEN(BLEN), .START_VAL(8'hFE)) dut_b (
    .CLK(clk), .RST_n(rst_n), .Enable(enable_b), .Mode(1'b0), .tx(txb.master),
    .Busy(busy_b), .Burst_Done_Sig(bdone_b), .Overrun(ovr_b));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0, n_total = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int rise_cnt_a = 0, last_rise_a = 0, bd_cnt_a = 0, last_bd_a = 0, bd_cnt_b = 0;
  int delay_a = 10;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic push_burst(input bit side_b, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2);
    if (side_b) begin
      qb.push_back(b0); qb.push_back(b1); qb.push_back(b2);
`ifdef UART_TX_BURST_CHKSUM_EN
      qb.push_back(b0 ^ b1 ^ b2);
`endif
    end else begin
      qa.push_back(b0); qa.push_back(b1); qa.push_back(b2);
`ifdef UART_TX_BURST_CHKSUM_EN
      qa.push_back(b0 ^ b1 ^ b2);
`endif
    end
  endtask

  task automatic wait_rise_a(input string name, output int at_cyc);
    int rc;
    int t;
    rc = rise_cnt_a;
    t = 0;
    while (rise_cnt_a == rc && t < 3000) begin
      @(posedge clk); #2; t++;
    end
    check({name, "_timeout"}, rise_cnt_a > rc, 1'b1);
    at_cyc = last_rise_a;
  endtask

  task automatic wait_bd_a(input int target);
    int t;
    t = 0;
    while (bd_cnt_a < target && t < 3000) begin
      @(posedge clk); #2; t++;
    end
    check("a_burst_wait_timeout", bd_cnt_a >= target, 1'b1);
  endtask

  // Mock tx_module A: done pulse delay_a cycles after the request rises.
  initial begin : mock_a
    bit armed;
    int cd;
    armed = 1'b0;
    cd = 0;
    txa.Tx_Done_Sig = 1'b0;
    forever begin
      @(negedge clk);
      txa.Tx_Done_Sig = 1'b0;
      if (!rst_n) armed = 1'b0;
      else if (!armed && txa.Tx_En_Sig) begin armed = 1'b1; cd = delay_a - 1; end
      else if (armed) begin
        cd--;
        if (cd <= 0) begin txa.Tx_Done_Sig = 1'b1; armed = 1'b0; end
      end
    end
  end

  initial begin : mock_b
    bit armed;
    int cd;
    armed = 1'b0;
    cd = 0;
    txb.Tx_Done_Sig = 1'b0;
    forever begin
      @(negedge clk);
      txb.Tx_Done_Sig = 1'b0;
      if (!rst_n) armed = 1'b0;
      else if (!armed && txb.Tx_En_Sig) begin armed = 1'b1; cd = 9; end
      else if (armed) begin
        cd--;
        if (cd <= 0) begin txb.Tx_Done_Sig = 1'b1; armed = 1'b0; end
      end
    end
  end

  initial begin : mon_a
    logic prev;
    logic [7:0] cur;
    int expv;
    prev = 1'b0;
    cur = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) prev = 1'b0;
      else begin
        if (txa.Tx_En_Sig && !prev) begin
          rise_cnt_a++;
          last_rise_a = cyc;
          cur = txa.Tx_Data;
          expv = (qa.size() > 0) ? int'(qa.pop_front()) : 32'h100;
          $display("A tx byte %02h at cycle %0d, expected %0h", cur, cyc, expv);
          check("a_data", cur, expv);
          check("a_busy_during_request", busy, 1'b1);
        end
        if (txa.Tx_Done_Sig && prev) check("a_data_stable", txa.Tx_Data, cur);
        if (bdone) begin bd_cnt_a++; last_bd_a = cyc; end
        prev = txa.Tx_En_Sig;
      end
    end
  end

  initial begin : mon_b
    logic prev;
    logic [7:0] cur;
    int expv;
    prev = 1'b0;
    cur = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) prev = 1'b0;
      else begin
        if (txb.Tx_En_Sig && !prev) begin
          cur = txb.Tx_Data;
          expv = (qb.size() > 0) ? int'(qb.pop_front()) : 32'h100;
          $display("B tx byte %02h at cycle %0d, expected %0h", cur, cyc, expv);
          check("b_data", cur, expv);
        end
        if (txb.Tx_Done_Sig && prev) check("b_data_stable", txb.Tx_Data, cur);
        if (bdone_b) bd_cnt_b++;
        prev = txb.Tx_En_Sig;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int c0;
    int r;
    int t;
    enable = 1'b1;
    enable_b = 1'b1;
    mode = 1'b0;
    #12;
    check("rst_tx_en", txa.Tx_En_Sig, 1'b0);
    check("rst_tx_data", txa.Tx_Data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_burst_done", bdone, 1'b0);
    check("rst_overrun", ovr, 1'b0);
    check("rst_tx_data_b", txb.Tx_Data, 8'hFE);

    // Counter mode from reset, plus the START_VAL wrap instance.
    push_burst(1'b0, 8'h00, 8'h01, 8'h02);
    push_burst(1'b0, 8'h03, 8'h04, 8'h05);
    push_burst(1'b1, 8'hFE, 8'hFF, 8'h00);
    @(negedge clk);
    c0 = cyc;
    rst_n = 1'b1;
    wait_rise_a("a_first_rise", r);
    check("a_first_rise_cycle", r - c0, 101);
    wait_bd_a(1);
    enable_b = 1'b0;
    wait_bd_a(2);
    check("a_bursts_counter", bd_cnt_a, 2);
    check("a_queue_empty_counter", qa.size(), 0);

    // Walking-one mode, three bursts including the 80 -> 01 wrap.
    @(negedge clk);
    mode = 1'b1;
    push_burst(1'b0, 8'h01, 8'h02, 8'h04);
    push_burst(1'b0, 8'h08, 8'h10, 8'h20);
    push_burst(1'b0, 8'h40, 8'h80, 8'h01);
    wait_bd_a(5);
    check("a_bursts_walk", bd_cnt_a, 5);
    check("a_queue_empty_walk", qa.size(), 0);
    check("a_overrun_still_clear", ovr, 1'b0);

    // Enable dropped after the first byte's done: burst completes, no more follow.
    @(negedge clk);
    mode = 1'b0;
    push_burst(1'b0, 8'h06, 8'h07, 8'h08);
    wait_rise_a("a_drop_rise", r);
    t = 0;
    while (!txa.Tx_Done_Sig && t < 100) begin @(posedge clk); #2; t++; end
    check("a_drop_done_timeout", t < 100, 1'b1);
    enable = 1'b0;
    wait_bd_a(6);
    repeat (400) @(posedge clk);
    #2;
    check("a_bursts_after_drop", bd_cnt_a, 6);
    check("a_queue_empty_drop", qa.size(), 0);
    check("a_idle_after_drop", busy, 1'b0);

    // Re-enable with a slow tx_module: counter restarts from 0, ticks latch, overrun.
    delay_a = 150;
    push_burst(1'b0, 8'h09, 8'h0A, 8'h0B);
    push_burst(1'b0, 8'h0C, 8'h0D, 8'h0E);
    @(negedge clk);
    c0 = cyc;
    enable = 1'b1;
    wait_rise_a("a_reenable_rise", r);
    check("a_reenable_rise_cycle", r - c0, 101);
    wait_bd_a(7);
    wait_rise_a("a_latched_rise", r);
    delay_a = 10;
    check("a_latched_start_gap", r - last_bd_a, 2);
    check("a_overrun_set", ovr, 1'b1);
    wait_bd_a(8);
    enable = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("a_queue_empty_slow", qa.size(), 0);
    check("a_overrun_sticky", ovr, 1'b1);

    // Asynchronous reset while a request is outstanding.
    push_burst(1'b0, 8'h0F, 8'h10, 8'h11);
    @(negedge clk);
    enable = 1'b1;
    wait_rise_a("a_pre_reset_rise", r);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_tx_en", txa.Tx_En_Sig, 1'b0);
    check("async_rst_tx_data", txa.Tx_Data, 8'h00);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_overrun", ovr, 1'b0);
    qa.delete();
    push_burst(1'b0, 8'h00, 8'h01, 8'h02);
    @(negedge clk);
    c0 = cyc;
    rst_n = 1'b1;
    wait_rise_a("a_post_reset_rise", r);
    check("a_post_reset_rise_cycle", r - c0, 101);
    wait_bd_a(9);
    check("a_queue_empty_reset", qa.size(), 0);
    check("b_bursts", bd_cnt_b, 1);
    check("b_queue_empty", qb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
